// File: rtl/idex_stage_hs.sv
// ---------------------------------------------------------------------------
// idex_stage_hs -- ID/EX pipeline register with valid/ready handshake and a
// two-entry (main + skid) buffer for the pipelined MIPS core.
//
// The main slot drives EX. The skid slot catches the one instruction that was
// accepted in the same cycle that EX stalled. An empty main slot always shows
// zeroed control bundles and operands, so EX sees a NOP.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   kill held and incoming instructions this cycle
//   in_valid / in_ready     upstream handshake (in_ready = ~skid valid)
//   in_pc4..in_wb           ID payload (operands, specifiers, control)
//   out_valid / out_ready   downstream handshake (main slot)
//   out_pc4..out_wb         main-slot payload
//
// Optional build macro IDEX_PERF_CNT_EN adds the following performance outputs:
//   stall_cnt[31:0]   cycles with out_valid & ~out_ready
//   flush_cnt[15:0]   cycles with flush asserted
//   bubble_cnt[31:0]  cycles out of reset with out_valid low
// All three counters wrap on overflow.
// ---------------------------------------------------------------------------
module idex_stage_hs #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int EX_W   = 4,
    parameter int MEM_W  = 4,
    parameter int WB_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [EX_W-1:0]   in_ex,
    input  logic [MEM_W-1:0]  in_mem,
    input  logic [WB_W-1:0]   in_wb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc4,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd,
    output logic [EX_W-1:0]   out_ex,
    output logic [MEM_W-1:0]  out_mem,
    output logic [WB_W-1:0]   out_wb
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       flush_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [EX_W-1:0]   ex;
        logic [MEM_W-1:0]  mem;
        logic [WB_W-1:0]   wb;
    } payload_t;

    // Turn a payload into a NOP: control bundles and operands cleared,
    // pc4 and register specifiers kept.
    function automatic payload_t make_nop(input payload_t p);
        payload_t r;
        r     = p;
        r.a   = {DATA_W{1'b0}};
        r.b   = {DATA_W{1'b0}};
        r.imm = {DATA_W{1'b0}};
        r.ex  = {EX_W{1'b0}};
        r.mem = {MEM_W{1'b0}};
        r.wb  = {WB_W{1'b0}};
        return r;
    endfunction

    payload_t in_pay_s;
    payload_t main_r, main_nxt_s;
    payload_t skid_r, skid_nxt_s;
    logic     main_valid_r, main_valid_nxt_s;
    logic     skid_valid_r, skid_valid_nxt_s;
    logic     accept_s;
    logic     drain_s;
    logic     load_main_s;

    assign in_pay_s = '{pc4: in_pc4, a: in_a, b: in_b, imm: in_imm,
                        rs: in_rs, rt: in_rt, rd: in_rd,
                        ex: in_ex, mem: in_mem, wb: in_wb};

    assign accept_s    = in_valid & ~skid_valid_r & ~flush;
    assign drain_s     = main_valid_r & out_ready;
    // Main slot is free to take new content when it is empty or being consumed.
    assign load_main_s = ~main_valid_r | drain_s;

    // Next-state for both slots: flush first, then refill or hold.
    always_comb begin
        main_nxt_s       = main_r;
        main_valid_nxt_s = main_valid_r;
        skid_nxt_s       = skid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (flush) begin
            main_valid_nxt_s = 1'b0;
            main_nxt_s       = make_nop(in_pay_s);
            skid_valid_nxt_s = 1'b0;
            skid_nxt_s       = '0;
        end else begin
            if (load_main_s) begin
                if (skid_valid_r) begin
                    main_nxt_s       = skid_r;
                    main_valid_nxt_s = 1'b1;
                    skid_valid_nxt_s = 1'b0;
                end else if (accept_s) begin
                    main_nxt_s       = in_pay_s;
                    main_valid_nxt_s = 1'b1;
                end else begin
                    main_nxt_s       = make_nop(main_r);
                    main_valid_nxt_s = 1'b0;
                end
            end else begin
                main_nxt_s       = main_r;
                main_valid_nxt_s = main_valid_r;
            end
            // Only a stalled, occupied main slot diverts an accept into skid.
            if (accept_s && main_valid_r && !out_ready) begin
                skid_nxt_s       = in_pay_s;
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_nxt_s = skid_r;
            end
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r       <= '0;
            main_valid_r <= 1'b0;
            skid_r       <= '0;
            skid_valid_r <= 1'b0;
        end else begin
            main_r       <= main_nxt_s;
            main_valid_r <= main_valid_nxt_s;
            skid_r       <= skid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
        end
    end

    assign in_ready  = ~skid_valid_r;
    assign out_valid = main_valid_r;
    assign out_pc4   = main_r.pc4;
    assign out_a     = main_r.a;
    assign out_b     = main_r.b;
    assign out_imm   = main_r.imm;
    assign out_rs    = main_r.rs;
    assign out_rt    = main_r.rt;
    assign out_rd    = main_r.rd;
    assign out_ex    = main_r.ex;
    assign out_mem   = main_r.mem;
    assign out_wb    = main_r.wb;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;
    logic [31:0] bubble_cnt_r;

    // Free-running event counters; the reset branch covers rst_n=0 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r  <= 32'd0;
            flush_cnt_r  <= 16'd0;
            bubble_cnt_r <= 32'd0;
        end else begin
            if (main_valid_r && !out_ready) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
            if (!main_valid_r) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
        end
    end

    assign stall_cnt  = stall_cnt_r;
    assign flush_cnt  = flush_cnt_r;
    assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_idex_stage_hs.sv
module tb_idex_stage_hs;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  ex;
        logic [3:0]  mem;
        logic [1:0]  wb;
    } pay_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc4, in_a, in_b, in_imm, out_pc4, out_a, out_b, out_imm;
    logic [4:0]  in_rs, in_rt, in_rd, out_rs, out_rt, out_rd;
    logic [3:0]  in_ex, in_mem, out_ex, out_mem;
    logic [1:0]  in_wb, out_wb;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt, bubble_cnt;
    logic [15:0] flush_cnt;
`endif

    pay_t in_p, out_p;
    assign {in_pc4, in_a, in_b, in_imm, in_rs, in_rt, in_rd, in_ex, in_mem, in_wb} = in_p;
    assign out_p = {out_pc4, out_a, out_b, out_imm, out_rs, out_rt, out_rd, out_ex, out_mem, out_wb};

    idex_stage_hs dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc4(in_pc4), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_ex(in_ex), .in_mem(in_mem), .in_wb(in_wb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc4(out_pc4), .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_ex(out_ex), .out_mem(out_mem), .out_wb(out_wb)
`ifdef IDEX_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the stage behaves as a 2-deep FIFO of instructions.
    pay_t        exp_q[$];
    logic        chk_en      = 1'b0;
    logic        model_ready = 1'b1;
    logic        model_valid = 1'b0;
    logic [31:0] last_pc4    = 32'd0;
    logic [4:0]  last_rs = 5'd0, last_rt = 5'd0, last_rd = 5'd0;
    logic [31:0] stall_m = 32'd0, bubble_m = 32'd0;
    logic [15:0] flush_m = 16'd0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string nm, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic pay_t rand_pay();
        pay_t p;
        p.pc4 = $urandom();
        p.a   = $urandom();
        p.b   = $urandom();
        p.imm = $urandom();
        p.rs  = 5'($urandom());
        p.rt  = 5'($urandom());
        p.rd  = 5'($urandom());
        p.ex  = 4'($urandom());
        p.mem = 4'($urandom());
        p.wb  = 2'($urandom());
        return p;
    endfunction

    // Monitor: compares DUT outputs against the model mid-cycle and pops on drain.
    always @(negedge clk) begin
        if (chk_en) begin
            model_valid = (exp_q.size() > 0);
            model_ready = (exp_q.size() < 2);
            check("out_valid", 160'(out_valid), 160'(model_valid));
            check("in_ready", 160'(in_ready), 160'(model_ready));
            if (model_valid) begin
                check("payload", 160'(out_p), 160'(exp_q[0]));
                last_pc4 = exp_q[0].pc4;
                last_rs  = exp_q[0].rs;
                last_rt  = exp_q[0].rt;
                last_rd  = exp_q[0].rd;
                if (out_ready && !flush) begin
                    void'(exp_q.pop_front());
                end
            end else begin
                check("idle_nop", 160'(out_p),
                      160'({last_pc4, 96'd0, last_rs, last_rt, last_rd, 10'd0}));
            end
        end
    end

    // Driver: presents one cycle of stimulus and records accepted instructions.
    task automatic step(input logic v, input logic ordy, input logic fl, input pay_t p);
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        in_p      = p;
        @(posedge clk);
        if (model_valid && !ordy) stall_m++;
        if (!model_valid) bubble_m++;
        if (fl) begin
            flush_m++;
            exp_q.delete();
            last_pc4 = p.pc4;
            last_rs  = p.rs;
            last_rt  = p.rt;
            last_rd  = p.rd;
        end else if (v && model_ready) begin
            exp_q.push_back(p);
        end
        #1;
    endtask

    initial begin
        pay_t p;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_p = '0;
        #3;
        check("rst_out_valid", 160'(out_valid), 160'd0);
        check("rst_in_ready", 160'(in_ready), 160'd1);
        check("rst_payload", 160'(out_p), 160'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Streaming: pc4 = 4, 8 .. 32 back to back.
        for (int i = 1; i <= 8; i++) begin
            p = rand_pay(); p.pc4 = 32'(4 * i);
            step(1'b1, 1'b1, 1'b0, p);
        end
        step(1'b0, 1'b1, 1'b0, rand_pay());
        step(1'b0, 1'b1, 1'b0, rand_pay());

        // Backpressure: 0x10 to main, 0x14 to skid, 0x18 refused.
        p = rand_pay(); p.pc4 = 32'h10; step(1'b1, 1'b0, 1'b0, p);
        p = rand_pay(); p.pc4 = 32'h14; step(1'b1, 1'b0, 1'b0, p);
        p = rand_pay(); p.pc4 = 32'h18; step(1'b1, 1'b0, 1'b0, p);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, rand_pay());

        // Flush while full; the instruction on the flush cycle is dropped.
        p = rand_pay(); p.ex = 4'hF; step(1'b1, 1'b0, 1'b0, p);
        step(1'b1, 1'b0, 1'b0, rand_pay());
        step(1'b1, 1'b0, 1'b1, rand_pay());
        step(1'b0, 1'b0, 1'b0, rand_pay());
        step(1'b0, 1'b1, 1'b0, rand_pay());

        // Drain with no follow-up: pc4 and specifiers hold, wb cleared.
        p = rand_pay(); p.wb = 2'b11; step(1'b1, 1'b1, 1'b0, p);
        step(1'b0, 1'b1, 1'b0, rand_pay());
        step(1'b0, 1'b1, 1'b0, rand_pay());

        // Asynchronous reset with both slots full.
        step(1'b1, 1'b0, 1'b0, rand_pay());
        step(1'b1, 1'b0, 1'b0, rand_pay());
        chk_en = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 160'(out_valid), 160'd0);
        check("mid_rst_payload", 160'(out_p), 160'd0);
        #1 rst_n = 1'b1;
        check("post_rst_in_ready", 160'(in_ready), 160'd1);
        exp_q.delete();
        model_ready = 1'b1;
        model_valid = 1'b0;
        last_pc4 = 32'd0; last_rs = 5'd0; last_rt = 5'd0; last_rd = 5'd0;
        stall_m = 32'd0; bubble_m = 32'd0; flush_m = 16'd0;
        chk_en = 1'b1;
        step(1'b0, 1'b1, 1'b0, rand_pay());

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 19) == 0), rand_pay());
        end
        step(1'b0, 1'b1, 1'b0, rand_pay());

`ifdef IDEX_PERF_CNT_EN
        check("stall_cnt", 160'(stall_cnt), 160'(stall_m));
        check("flush_cnt", 160'(flush_cnt), 160'(flush_m));
        check("bubble_cnt", 160'(bubble_cnt), 160'(bubble_m));
`endif
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
